knn_host_if: RTL and testbench
==============================

KNN_HOST_IF -- requirements
Module: knn_host_if

Interface
REQ-001 The block SHALL have parameter NPoints, default 17, meaning the training-table depth.
REQ-002 The block SHALL have parameter Classes, default 2, meaning the number of classes; the class width is clog2(Classes).
REQ-003 The block SHALL have parameter Latency, default 2, meaning the cycles from a knn_din_o change to a valid knn_dout_i (2 with classifier FFs, 0 without).
REQ-004 Port clk_i, input, 1 bit: the single clock, rising edge.
REQ-005 Port rstn_i, input, 1 bit: asynchronous active-low reset.
REQ-006 Port ld_valid_i, input, 1 bit: a training entry is offered.
REQ-007 Port ld_ready_o, output, 1 bit: the block accepts a training entry.
REQ-008 Port ld_point_i, input, 32 bits: training point, x in [31:16], y in [15:0].
REQ-009 Port ld_class_i, input, clog2(Classes) bits: the training label.
REQ-010 Port clear_i, input, 1 bit: discard the training table.
REQ-011 Port q_valid_i / q_ready_o, input / output, 1 bit each: query handshake.
REQ-012 Port q_point_i, input, 32 bits: the query point.
REQ-013 Port r_valid_o / r_ready_i, output / input, 1 bit each: result handshake.
REQ-014 Port r_class_o, output, clog2(Classes) bits: the classification result.
REQ-015 Port knn_points_o, output, NPoints x 32 bits: the table driven to the classifier.
REQ-016 Port knn_classes_o, output, NPoints x clog2(Classes) bits: the labels driven to the classifier.
REQ-017 Port knn_din_o, output, 32 bits: the query driven to the classifier.
REQ-018 Port knn_dout_i, input, clog2(Classes) bits: the classifier result.
REQ-019 Port count_o, output, clog2(NPoints+1) bits: the number of entries loaded.

Function
REQ-020 The block SHALL implement FSM states LOAD, READY, WAIT and RESP.
REQ-021 In LOAD, ld_ready_o SHALL be 1; on ld_valid_i and ld_ready_o, the block SHALL write entry[count_o] and increment count_o.
REQ-022 When the accepted entry makes count_o equal NPoints, the FSM SHALL go to READY on the same edge; further loads SHALL NOT be accepted.
REQ-023 In READY, q_ready_o SHALL be 1; on q_valid_i, the block SHALL register q_point_i into knn_din_o, load the wait counter with Latency, and go to WAIT.
REQ-024 In WAIT, the counter SHALL decrement each cycle; when it is 0, the block SHALL capture knn_dout_i into r_class_o, set r_valid_o, and go to RESP.
REQ-025 r_valid_o SHALL rise exactly Latency+1 cycles after the query-accept edge (3 cycles at default).
REQ-026 In RESP, r_valid_o and r_class_o SHALL hold stable until r_ready_i; on r_ready_i, the FSM SHALL go to READY and r_valid_o SHALL fall on that edge.
REQ-027 q_ready_o and ld_ready_o SHALL be 0 in WAIT and RESP; knn_points_o, knn_classes_o and knn_din_o SHALL be frozen in WAIT and RESP.
REQ-028 clear_i in LOAD or READY SHALL set count_o to 0, zero every table entry, and go to LOAD; in LOAD, clear_i SHALL take priority over a simultaneous load.
REQ-029 clear_i in WAIT or RESP SHALL be ignored.
REQ-030 In READY, clear_i SHALL take priority over a simultaneous q_valid_i, and the query SHALL NOT be accepted.
REQ-031 knn_din_o SHALL retain the last query until the next accepted query.
REQ-032 The output ld_ready_o SHALL depend on state only, and the output q_ready_o SHALL depend on state only, with no combinational path from valid inputs.

Reset
REQ-033 On rstn_i low, the block SHALL asynchronously enter state LOAD.
REQ-034 On rstn_i low, count_o, all table entries, knn_din_o, r_class_o and r_valid_o SHALL be 0.
REQ-035 On rstn_i low, ld_ready_o SHALL be 1 and q_ready_o SHALL be 0.
REQ-036 Reset asserted in WAIT or RESP SHALL abort the query with no result delivered.

Verification
REQ-037 Load 17 entries back-to-back with point i = {i, i} and class i[0] -> count_o steps 1..17, ld_ready_o drops on the edge accepting entry 17, knn_points_o[16] = 0x00100010.
REQ-038 In READY, query 0x00050005 with a model classifier of Latency 2 returning 1 -> r_valid_o rises 3 cycles after accept with r_class_o = 1; q_ready_o = 0 throughout.
REQ-039 Hold r_ready_i low 5 cycles in RESP -> r_valid_o and r_class_o stay stable, no second query accepted; r_ready_i = 1 -> READY on the next edge.
REQ-040 Assert clear_i and ld_valid_i together at count_o = 8 -> count_o = 0, entry 8 not written, all knn_points_o = 0.
REQ-041 Assert clear_i during WAIT -> ignored, result still delivered, count_o stays 17.
REQ-042 Drop rstn_i mid-WAIT -> all outputs at reset values immediately, no r_valid_o pulse; Latency = 0 build -> r_valid_o rises 1 cycle after accept.

Source files
------------

// File: rtl/knn_host_if.sv
// Host-side wrapper for a k-NN classifier: loads the training table, issues one
// query at a time, waits a fixed classifier latency and hands back the class.
module knn_host_if #(
  parameter int NPoints = 17,
  parameter int Classes = 2,
  parameter int Latency = 2,
  localparam int CW = (Classes > 1) ? $clog2(Classes) : 1,
  localparam int NW = $clog2(NPoints + 1)
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          ld_valid_i,
  output logic                          ld_ready_o,
  input  logic [31:0]                   ld_point_i,
  input  logic [CW-1:0]                 ld_class_i,
  input  logic                          clear_i,
  input  logic                          q_valid_i,
  output logic                          q_ready_o,
  input  logic [31:0]                   q_point_i,
  output logic                          r_valid_o,
  input  logic                          r_ready_i,
  output logic [CW-1:0]                 r_class_o,
  output logic [NPoints-1:0][31:0]      knn_points_o,
  output logic [NPoints-1:0][CW-1:0]    knn_classes_o,
  output logic [31:0]                   knn_din_o,
  input  logic [CW-1:0]                 knn_dout_i,
  output logic [NW-1:0]                 count_o
);

  localparam int LW = (Latency > 0) ? $clog2(Latency + 1) : 1;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    READY = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                     state_q;
  logic [NW-1:0]              count_q;
  logic [NW-1:0]              count_d;
  logic [LW-1:0]              wait_q;
  logic [NPoints-1:0][31:0]   pts_q;
  logic [NPoints-1:0][CW-1:0] cls_q;
  logic [31:0]                din_q;
  logic [CW-1:0]              rcls_q;
  logic                       rvalid_q;

  assign count_d = count_q + NW'(1);

  // Handshake readies are pure state decodes so no valid input reaches them.
  assign ld_ready_o    = (state_q == LOAD);
  assign q_ready_o     = (state_q == READY);
  assign r_valid_o     = rvalid_q;
  assign r_class_o     = rcls_q;
  assign knn_points_o  = pts_q;
  assign knn_classes_o = cls_q;
  assign knn_din_o     = din_q;
  assign count_o       = count_q;

  // Control FSM together with table, query and result registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= LOAD;
      count_q  <= '0;
      wait_q   <= '0;
      pts_q    <= '0;
      cls_q    <= '0;
      din_q    <= 32'd0;
      rcls_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (clear_i) begin
            count_q <= '0;
            pts_q   <= '0;
            cls_q   <= '0;
          end else if (ld_valid_i) begin
            for (int i = 0; i < NPoints; i++) begin
              if (count_q == NW'(i)) begin
                pts_q[i] <= ld_point_i;
                cls_q[i] <= ld_class_i;
              end
            end
            count_q <= count_d;
            if (count_d == NW'(NPoints)) begin
              state_q <= READY;
            end
          end
        end
        READY: begin
          // A clear wins over a query offered on the same cycle.
          if (clear_i) begin
            count_q <= '0;
            pts_q   <= '0;
            cls_q   <= '0;
            state_q <= LOAD;
          end else if (q_valid_i) begin
            din_q   <= q_point_i;
            wait_q  <= LW'(Latency);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (wait_q == '0) begin
            rcls_q   <= knn_dout_i;
            rvalid_q <= 1'b1;
            state_q  <= RESP;
          end else begin
            wait_q <= wait_q - LW'(1);
          end
        end
        RESP: begin
          if (r_ready_i) begin
            rvalid_q <= 1'b0;
            state_q  <= READY;
          end
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_knn_host_if.sv
// Directed bench for knn_host_if: stimulus pushes expected results into a
// scoreboard that a separate monitor drains whenever r_valid_o rises.
module tb_knn_host_if;

  localparam int NP = 17;
  localparam int CW = 1;
  localparam int NW = 5;

  logic                  clk_i = 1'b0;
  logic                  rstn_i;
  logic                  ld_valid_i, ld_ready_o, clear_i;
  logic [31:0]           ld_point_i, q_point_i, knn_din_o;
  logic [CW-1:0]         ld_class_i, r_class_o, knn_dout_i;
  logic                  q_valid_i, q_ready_o, r_valid_o, r_ready_i;
  logic [NP-1:0][31:0]   knn_points_o;
  logic [NP-1:0][CW-1:0] knn_classes_o;
  logic [NW-1:0]         count_o;

  // Zero-latency instance with a two-entry table.
  logic                  ld_valid0, ld_ready0, clear0, q_valid0, q_ready0;
  logic                  r_valid0, r_ready0;
  logic [31:0]           ld_point0, q_point0, knn_din0;
  logic [CW-1:0]         ld_class0, r_class0, knn_dout0;
  logic [1:0][31:0]      knn_points0;
  logic [1:0][CW-1:0]    knn_classes0;
  logic [1:0]            count0;

  logic [CW-1:0] mdl1 = '0;
  logic [CW-1:0] mdl2 = '0;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  logic          rv_prev = 1'b0;
  logic [CW-1:0] exp_cls_q[$];
  int            exp_cyc_q[$];

  knn_host_if #(.NPoints(NP), .Classes(2), .Latency(2)) u_dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_point_i(ld_point_i),
    .ld_class_i(ld_class_i), .clear_i(clear_i),
    .q_valid_i(q_valid_i), .q_ready_o(q_ready_o), .q_point_i(q_point_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_class_o(r_class_o),
    .knn_points_o(knn_points_o), .knn_classes_o(knn_classes_o),
    .knn_din_o(knn_din_o), .knn_dout_i(knn_dout_i), .count_o(count_o)
  );

  knn_host_if #(.NPoints(2), .Classes(2), .Latency(0)) u_dut0 (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .ld_valid_i(ld_valid0), .ld_ready_o(ld_ready0), .ld_point_i(ld_point0),
    .ld_class_i(ld_class0), .clear_i(clear0),
    .q_valid_i(q_valid0), .q_ready_o(q_ready0), .q_point_i(q_point0),
    .r_valid_o(r_valid0), .r_ready_i(r_ready0), .r_class_o(r_class0),
    .knn_points_o(knn_points0), .knn_classes_o(knn_classes0),
    .knn_din_o(knn_din0), .knn_dout_i(knn_dout0), .count_o(count0)
  );

  always #5 clk_i = ~clk_i;

  // Model classifier: class = query bit 0, two register stages deep.
  always @(posedge clk_i) begin
    mdl1 <= knn_din_o[0];
    mdl2 <= mdl1;
    cyc  <= cyc + 1;
  end
  assign knn_dout_i = mdl2;
  assign knn_dout0  = knn_din0[0];

  // Scoreboard monitor: every rising r_valid_o must match the oldest expectation.
  always @(negedge clk_i) begin
    if (rstn_i && r_valid_o && !rv_prev) begin
      checks++;
      if (exp_cls_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: r_valid_o rose at cycle %0d with nothing pending", cyc);
      end else begin
        logic [CW-1:0] ec;
        int            ecyc;
        ec   = exp_cls_q.pop_front();
        ecyc = exp_cyc_q.pop_front();
        if (r_class_o !== ec || cyc != ecyc) begin
          errors++;
          $display("FAIL result: class %0d at cycle %0d, expected class %0d at cycle %0d",
                   r_class_o, cyc, ec, ecyc);
        end
      end
    end
    rv_prev = r_valid_o;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load_n(input int n);
    for (int i = 0; i < n; i++) begin
      ld_valid_i = 1'b1;
      ld_point_i = {16'(i), 16'(i)};
      ld_class_i = CW'(i % 2);
      tick();
      check("count_step", 64'(count_o), 64'(i + 1));
    end
    ld_valid_i = 1'b0;
  endtask

  task automatic accept(input logic [31:0] pt, input logic [CW-1:0] cls);
    q_valid_i = 1'b1;
    q_point_i = pt;
    tick();
    q_valid_i = 1'b0;
    exp_cls_q.push_back(cls);
    exp_cyc_q.push_back(cyc + 3);
    check("q_ready_wait", 64'(q_ready_o), 64'd0);
    check("ld_ready_wait", 64'(ld_ready_o), 64'd0);
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (!r_valid_o && n < 10) begin
      check("q_ready_wait_loop", 64'(q_ready_o), 64'd0);
      tick();
      n++;
    end
    if (!r_valid_o) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: r_valid_o never rose, got 0 expected 1");
    end
  endtask

  task automatic finish_resp();
    r_ready_i = 1'b1;
    tick();
    r_ready_i = 1'b0;
    check("r_valid_fall", 64'(r_valid_o), 64'd0);
    check("ready_after_resp", 64'(q_ready_o), 64'd1);
  endtask

  initial begin
    rstn_i = 1'b0; ld_valid_i = 1'b0; ld_point_i = 32'd0; ld_class_i = '0;
    clear_i = 1'b0; q_valid_i = 1'b0; q_point_i = 32'd0; r_ready_i = 1'b0;
    ld_valid0 = 1'b0; ld_point0 = 32'd0; ld_class0 = '0; clear0 = 1'b0;
    q_valid0 = 1'b0; q_point0 = 32'd0; r_ready0 = 1'b0;
    #2;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_ld_ready", 64'(ld_ready_o), 64'd1);
    check("rst_q_ready", 64'(q_ready_o), 64'd0);
    check("rst_r_valid", 64'(r_valid_o), 64'd0);
    check("rst_din", 64'(knn_din_o), 64'd0);
    check("rst_points_zero", 64'(knn_points_o == '0), 64'd1);
    #10 rstn_i = 1'b1;
    tick();

    // Back-to-back load of the full table.
    load_n(NP);
    check("ld_ready_full", 64'(ld_ready_o), 64'd0);
    check("q_ready_full", 64'(q_ready_o), 64'd1);
    check("point16", 64'(knn_points_o[16]), 64'h0010_0010);
    check("class3", 64'(knn_classes_o[3]), 64'd1);
    ld_valid_i = 1'b1;
    tick();
    ld_valid_i = 1'b0;
    check("no_load_when_full", 64'(count_o), 64'd17);

    // Query, then hold the result under backpressure with another query offered.
    accept(32'h0005_0005, 1'b1);
    wait_result();
    q_valid_i = 1'b1;
    q_point_i = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("resp_hold_valid", 64'(r_valid_o), 64'd1);
      check("resp_hold_class", 64'(r_class_o), 64'd1);
      check("resp_no_query", 64'(knn_din_o), 64'h0005_0005);
    end
    q_valid_i = 1'b0;
    finish_resp();

    // Clear during WAIT is ignored.
    accept(32'h0004_0004, 1'b0);
    clear_i = 1'b1;
    wait_result();
    clear_i = 1'b0;
    check("clear_wait_count", 64'(count_o), 64'd17);
    finish_resp();
    check("din_retained", 64'(knn_din_o), 64'h0004_0004);

    // Clear from READY, reload to 8, then clear beats a simultaneous load.
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clear_ready_count", 64'(count_o), 64'd0);
    check("clear_ready_ld_ready", 64'(ld_ready_o), 64'd1);
    load_n(8);
    clear_i = 1'b1;
    ld_valid_i = 1'b1;
    ld_point_i = 32'h0008_0008;
    tick();
    clear_i = 1'b0;
    ld_valid_i = 1'b0;
    check("clear_ld_count", 64'(count_o), 64'd0);
    check("clear_ld_points", 64'(knn_points_o == '0), 64'd1);
    check("clear_ld_classes", 64'(knn_classes_o == '0), 64'd1);

    // Clear beats a simultaneous query in READY.
    load_n(NP);
    clear_i = 1'b1;
    q_valid_i = 1'b1;
    q_point_i = 32'h0000_aaaa;
    tick();
    clear_i = 1'b0;
    q_valid_i = 1'b0;
    check("clear_q_ld_ready", 64'(ld_ready_o), 64'd1);
    check("clear_q_count", 64'(count_o), 64'd0);
    check("clear_q_din", 64'(knn_din_o), 64'h0004_0004);

    // Reset mid-WAIT aborts the query.
    load_n(NP);
    accept(32'h0005_0005, 1'b1);
    tick();
    rstn_i = 1'b0;
    #1;
    exp_cls_q.delete();
    exp_cyc_q.delete();
    check("abort_r_valid", 64'(r_valid_o), 64'd0);
    check("abort_count", 64'(count_o), 64'd0);
    check("abort_din", 64'(knn_din_o), 64'd0);
    check("abort_ld_ready", 64'(ld_ready_o), 64'd1);
    check("abort_q_ready", 64'(q_ready_o), 64'd0);
    check("abort_points", 64'(knn_points_o == '0), 64'd1);
    tick();
    rstn_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_no_pulse", 64'(r_valid_o), 64'd0);
    end

    // Zero-latency build answers one cycle after accept.
    ld_valid0 = 1'b1;
    ld_point0 = 32'h0001_0001;
    ld_class0 = 1'b1;
    tick();
    tick();
    ld_valid0 = 1'b0;
    check("l0_count", 64'(count0), 64'd2);
    check("l0_q_ready", 64'(q_ready0), 64'd1);
    q_valid0 = 1'b1;
    q_point0 = 32'h0007_0007;
    tick();
    q_valid0 = 1'b0;
    check("l0_no_valid_at_accept", 64'(r_valid0), 64'd0);
    tick();
    check("l0_valid", 64'(r_valid0), 64'd1);
    check("l0_class", 64'(r_class0), 64'd1);

    check("scoreboard_empty", 64'(exp_cls_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
